exec_wb: RTL and testbench
==========================

EXEC_WB -- requirements
Module: exec_wb

Interface
REQ-001 Parameter DW, 24, datapath width.
REQ-002 Parameter AW, 4, register address width (16 registers).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 issue_valid  in  1  instruction offered.
REQ-006 issue_ready  out  1  instruction accepted on edge when issue_valid && issue_ready.
REQ-007 issue_op  in  4  opcode; issue_dst / issue_srca / issue_srcb  in  AW each; issue_imm  in  8.
REQ-008 src0, src1  out  AW  regfile read addresses, combinationally equal to issue_srca / issue_srcb.
REQ-009 outa, outb  in  DW  regfile combinational read data for src0 / src1.
REQ-010 we  out  1, dst  out  AW, data  out  DW  regfile write port; the regfile commits on the edge ending a cycle with we=1.
REQ-011 err  out  1  one-cycle pulse for a reserved opcode; busy  out  1  multiplier active.

Function
REQ-012 Opcodes: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 SHL a by b[4:0], 6 SHR (logical) a by b[4:0], 7 ROT3 (rotate a left 3 bits), 8 MOVA (a), 9 LDI (imm zero-extended), 10 NOP, 11 MUL; 12-15 reserved.
REQ-013 Arithmetic is modulo 2^DW; carries are discarded; shift amounts >= 24 yield 0.
REQ-014 Operand a/b = forwarded value for srca/srcb, by priority: E stage (valid, writing, e_dst match) ALU result > W stage (w_valid, w_dst match) w_data > outa/outb.
REQ-015 Pipeline: accept edge N loads E (op, dst, a, b, imm); edge N+1 loads W from ALU; we=1 during cycle N+2; regfile updated at edge N+2 end.
REQ-016 Back-to-back issue every cycle is supported while not in MUL; each instruction sees every prior result via REQ-014.
REQ-017 NOP and reserved ops flow through E but never assert we; a reserved op sets err=1 for exactly the cycle after acceptance.
REQ-018 FSM states IDLE, MUL; issue_ready = (state==IDLE); busy = (state==MUL).
REQ-019 Accepting MUL: E loads a bubble; FSM IDLE->MUL; acc=0, mcand=a, mplier=b, count=0.
REQ-020 Each MUL cycle: acc += mcand if mplier[0]; mcand <<= 1; mplier >>= 1; count++; after 24 iterations, the same edge loads W (acc low DW bits) and returns the FSM to IDLE.
REQ-021 MUL accepted at edge N: issue_ready low in cycles N+1..N+24; we=1 in cycle N+25; issue_ready high in N+25, with forwarding from W applied.
REQ-022 The W stage is loaded at most once per edge; E-stage and MUL completion cannot coincide because MUL issues a bubble into E.
REQ-023 issue_valid while issue_ready=0 is ignored, with no state change; the source holds the instruction.
REQ-024 dst=0 is writable; there is no hardwired-zero register.

Reset
REQ-025 When rst=1 at an edge: E/W valid cleared, FSM IDLE, count=0, we=0, dst=0, data=0, err=0, busy=0; issue_ready=1 the following cycle.
REQ-026 Reset during MUL or with E/W valid discards the pending results; no write occurs after reset.
REQ-027 Reset has priority over an issue accepted on the same edge.

Structure
REQ-028 Package exec_pkg holds DW, AW, the opcode enumeration, MUL_ITER=24, and the FSM state type.
REQ-029 A combinational sub-module exec_alu (op, a, b, imm -> result, writes, reserved) implements REQ-012/013; the MUL FSM and forwarding stay in exec_wb.

Verification
REQ-030 r12=1, r11=3; ADD r4,r12,r11 accepted at N -> we=1, dst=4, data=0x000004 in cycle N+2.
REQ-031 ADD r4,r12,r12 then next cycle ADD r5,r4,r4 -> r5=0x000004 (E forwarding); repeat with a one-cycle NOP gap -> r5=0x000004 (W forwarding).
REQ-032 ROT3 of 0xE00001 -> 0x00000F; SHL 0x000001 by 24 -> 0x000000; SUB 0-1 -> 0xFFFFFF.
REQ-033 MUL r5,r11,r11 at N -> issue_ready=0 and busy=1 for 24 cycles; we=1, data=0x000009 in cycle N+25; MUL 0x001000*0x001000 -> 0x000000.
REQ-034 Opcode 0xF accepted -> err=1 for one cycle and no we; rst asserted in MUL cycle 10 -> no write, issue_ready=1 next cycle.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared widths, opcode map and MUL FSM state type for the exec/writeback pipeline.
package exec_pkg;

   localparam int DW       = 24;
   localparam int AW       = 4;
   localparam int MUL_ITER = 24;
   localparam int CW       = $clog2(MUL_ITER + 1);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SHL  = 4'd5,
      OP_SHR  = 4'd6,
      OP_ROT3 = 4'd7,
      OP_MOVA = 4'd8,
      OP_LDI  = 4'd9,
      OP_NOP  = 4'd10,
      OP_MUL  = 4'd11
   } op_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/exec_alu.sv
// Single-cycle ALU for the E stage; purely combinational, no backpressure.
// Flags whether the op writes back and whether the opcode is reserved (12-15).
module exec_alu
   import exec_pkg::*;
#(
   parameter int DW = exec_pkg::DW
) (
   input  logic [3:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [7:0]    imm,
   output logic [DW-1:0] result,
   output logic          writes,
   output logic          reserved
);

   always_comb begin
      result   = '0;
      writes   = 1'b1;
      reserved = 1'b0;
      case (op)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         // a 5-bit amount of DW or more shifts every bit out, giving zero
         OP_SHL:  result = a << b[4:0];
         OP_SHR:  result = a >> b[4:0];
         OP_ROT3: result = {a[DW-4:0], a[DW-1:DW-3]};
         OP_MOVA: result = a;
         OP_LDI:  result = {{(DW-8){1'b0}}, imm};
         OP_NOP, OP_MUL: writes = 1'b0;
         default: begin
            writes   = 1'b0;
            reserved = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/exec_wb.sv
// Issue -> E -> W pipeline with E/W operand forwarding and a 24-cycle shift-add MUL.
// Result written 2 cycles after accept (MUL: 25); issue_ready drops only while MUL iterates.
module exec_wb
   import exec_pkg::*;
#(
   parameter int DW = exec_pkg::DW,
   parameter int AW = exec_pkg::AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          issue_valid,
   output logic          issue_ready,
   input  logic [3:0]    issue_op,
   input  logic [AW-1:0] issue_dst,
   input  logic [AW-1:0] issue_srca,
   input  logic [AW-1:0] issue_srcb,
   input  logic [7:0]    issue_imm,
   output logic [AW-1:0] src0,
   output logic [AW-1:0] src1,
   input  logic [DW-1:0] outa,
   input  logic [DW-1:0] outb,
   output logic          we,
   output logic [AW-1:0] dst,
   output logic [DW-1:0] data,
   output logic          err,
   output logic          busy
);

   state_t        state, state_nxt;
   logic          e_valid, w_valid;
   logic [3:0]    e_op;
   logic [AW-1:0] e_dst, w_dst, m_dst;
   logic [DW-1:0] e_a, e_b, w_data;
   logic [7:0]    e_imm;
   logic [DW-1:0] acc, mcand, mplier, acc_nxt;
   logic [CW-1:0] count;
   logic [DW-1:0] alu_res, opa, opb;
   logic          alu_wr, alu_rsv, e_wr, fire, is_mul, mul_done;

   assign src0     = issue_srca;
   assign src1     = issue_srcb;
   assign fire     = issue_valid && issue_ready;
   assign is_mul   = (issue_op == OP_MUL);
   assign e_wr     = e_valid && alu_wr;
   assign mul_done = (state == S_MUL) && (count == CW'(MUL_ITER - 1));
   assign acc_nxt  = mplier[0] ? acc + mcand : acc;

   exec_alu #(.DW(DW)) u_alu (
      .op       (e_op),
      .a        (e_a),
      .b        (e_b),
      .imm      (e_imm),
      .result   (alu_res),
      .writes   (alu_wr),
      .reserved (alu_rsv)
   );

   // Youngest producer wins: E result, then the W value not yet committed to the regfile.
   always_comb begin
      opa = outa;
      opb = outb;
      if (e_wr && e_dst == issue_srca)         opa = alu_res;
      else if (w_valid && w_dst == issue_srca) opa = w_data;
      if (e_wr && e_dst == issue_srcb)         opb = alu_res;
      else if (w_valid && w_dst == issue_srcb) opb = w_data;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      issue_ready = 1'b0;
      busy        = 1'b0;
      case (state)
         S_IDLE: begin
            issue_ready = 1'b1;
            if (issue_valid && is_mul) state_nxt = S_MUL;
         end
         S_MUL: begin
            busy = 1'b1;
            if (mul_done) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e_valid <= 1'b0;
         e_op    <= '0;
         e_dst   <= '0;
         e_a     <= '0;
         e_b     <= '0;
         e_imm   <= '0;
         w_valid <= 1'b0;
         w_dst   <= '0;
         w_data  <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         count   <= '0;
         m_dst   <= '0;
      end else begin
         // MUL leaves a bubble in E so its completion never competes with E for W
         e_valid <= fire && !is_mul;
         if (fire) begin
            e_op  <= issue_op;
            e_dst <= issue_dst;
            e_a   <= opa;
            e_b   <= opb;
            e_imm <= issue_imm;
         end
         if (mul_done) begin
            w_valid <= 1'b1;
            w_dst   <= m_dst;
            w_data  <= acc_nxt;
         end else begin
            w_valid <= e_wr;
            if (e_wr) begin
               w_dst  <= e_dst;
               w_data <= alu_res;
            end
         end
         if (fire && is_mul) begin
            acc    <= '0;
            mcand  <= opa;
            mplier <= opb;
            count  <= '0;
            m_dst  <= issue_dst;
         end else if (state == S_MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
         end
      end
   end

   assign we   = w_valid;
   assign dst  = w_dst;
   assign data = w_data;
   assign err  = e_valid && alu_rsv;

endmodule

// File: tb/tb_exec_wb.sv
// Bench for exec_wb: acts as the regfile, checks every writeback against an in-order
// architectural model (value, destination and cycle), plus ready/busy/err each cycle.
module tb_exec_wb;
   import exec_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          issue_valid, issue_ready;
   logic [3:0]    issue_op;
   logic [AW-1:0] issue_dst, issue_srca, issue_srcb;
   logic [7:0]    issue_imm;
   logic [AW-1:0] src0, src1, dst;
   logic [DW-1:0] outa, outb, data;
   logic          we, err, busy;

   always #5 clk = ~clk;

   exec_wb #(.DW(DW), .AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_op    (issue_op),
      .issue_dst   (issue_dst),
      .issue_srca  (issue_srca),
      .issue_srcb  (issue_srcb),
      .issue_imm   (issue_imm),
      .src0        (src0),
      .src1        (src1),
      .outa        (outa),
      .outb        (outb),
      .we          (we),
      .dst         (dst),
      .data        (data),
      .err         (err),
      .busy        (busy)
   );

   // Regfile: combinational read, write on the edge ending a we cycle; preload port for setup.
   logic [DW-1:0] rf [16] = '{default: '0};
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [DW-1:0] pl_val;
   assign outa = rf[src0];
   assign outb = rf[src1];
   always @(posedge clk) begin
      if (pl_en)   rf[pl_addr] <= pl_val;
      else if (we) rf[dst] <= data;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] dst;
      logic [DW-1:0] data;
      int            cyc;
   } wr_t;

   typedef struct {
      logic [3:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [7:0]    imm;
      logic [DW-1:0] exp;
   } vec_t;

   logic [DW-1:0] arch [16];
   wr_t           exp_q [$];
   bit            err_at [int];
   int            mul_lo = 1, mul_hi = 0;
   bit            mon_en = 1'b0;
   int            n_checks = 0, n_fail = 0;
   vec_t          vt [22];
   bit            in_mul;
   wr_t           w;
   int            t0;
   logic [3:0]    rop;
   int            rd, rsa, rsb;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result, from the opcode definitions with plain integer arithmetic.
   function automatic logic [DW-1:0] ref_result(input logic [3:0] op, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b, input logic [7:0] imm);
      longint unsigned ua, ub, m, r;
      int sh;
      ua = a;
      ub = b;
      m  = 64'h100_0000;
      sh = int'(ub % 64'd32);
      case (op)
         4'd0:    r = (ua + ub) % m;
         4'd1:    r = (ua + m - ub) % m;
         4'd2:    r = ua & ub;
         4'd3:    r = ua | ub;
         4'd4:    r = ua ^ ub;
         4'd5:    r = (sh >= 24) ? 64'd0 : (ua * (64'd1 << sh)) % m;
         4'd6:    r = (sh >= 24) ? 64'd0 : ua / (64'd1 << sh);
         4'd7:    r = (ua * 64'd8 + ua / 64'h20_0000) % m;
         4'd8:    r = ua;
         4'd9:    r = 64'(imm);
         4'd11:   r = (ua * ub) % m;
         default: r = 64'd0;
      endcase
      return r[DW-1:0];
   endfunction

   // Called at the negedge before the accepting edge; that edge makes cyc == n.
   task automatic model_accept(input logic [3:0] op, input int d, input int sa, input int sb,
                               input logic [7:0] imm);
      int n;
      logic [DW-1:0] r;
      wr_t e;
      n = cyc + 1;
      if (op <= 4'd9 || op == 4'd11) begin
         r = ref_result(op, arch[sa], arch[sb], imm);
         arch[d] = r;
         e.dst  = AW'(d);
         e.data = r;
         e.cyc  = (op == 4'd11) ? n + 24 : n + 1;
         exp_q.push_back(e);
      end
      if (op == 4'd11) begin
         mul_lo = n;
         mul_hi = n + 23;
      end
      if (op >= 4'd12) err_at[n] = 1'b1;
   endtask

   task automatic preload(input int addr, input logic [DW-1:0] val);
      pl_addr = AW'(addr);
      pl_val  = val;
      pl_en   = 1'b1;
      arch[addr] = val;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic issue(input logic [3:0] op, input int d, input int sa, input int sb,
                        input logic [7:0] imm);
      int g = 0;
      issue_op    = op;
      issue_dst   = AW'(d);
      issue_srca  = AW'(sa);
      issue_srcb  = AW'(sb);
      issue_imm   = imm;
      issue_valid = 1'b1;
      while (!issue_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!issue_ready) begin
         check("issue_timeout", issue_ready, 1'b1);
         issue_valid = 1'b0;
      end else begin
         model_accept(op, d, sa, sb, imm);
         @(negedge clk);
         issue_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         in_mul = (cyc >= mul_lo) && (cyc <= mul_hi);
         check("issue_ready", issue_ready, !in_mul);
         check("busy", busy, in_mul);
         if (err || err_at.exists(cyc)) check("err", err, err_at.exists(cyc));
         if (we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_we", we, 1'b0);
            end else begin
               w = exp_q.pop_front();
               check("wb_dst", dst, w.dst);
               check("wb_data", data, w.data);
               check("wb_cycle", cyc, w.cyc);
            end
         end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            check("missed_we", we, 1'b1);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      vt[0]  = '{OP_ADD,  24'h000001, 24'h000003, 8'h00, 24'h000004};
      vt[1]  = '{OP_ADD,  24'hFFFFFF, 24'h000002, 8'h00, 24'h000001};
      vt[2]  = '{OP_SUB,  24'h000000, 24'h000001, 8'h00, 24'hFFFFFF};
      vt[3]  = '{OP_SUB,  24'h000005, 24'h000003, 8'h00, 24'h000002};
      vt[4]  = '{OP_AND,  24'hF0F0F0, 24'hFF00FF, 8'h00, 24'hF000F0};
      vt[5]  = '{OP_OR,   24'h0F0000, 24'h0000F0, 8'h00, 24'h0F00F0};
      vt[6]  = '{OP_XOR,  24'hAAAAAA, 24'hFFFF00, 8'h00, 24'h5555AA};
      vt[7]  = '{OP_SHL,  24'h000001, 24'h000018, 8'h00, 24'h000000};
      vt[8]  = '{OP_SHL,  24'h000001, 24'h000017, 8'h00, 24'h800000};
      vt[9]  = '{OP_SHL,  24'h000003, 24'h000025, 8'h00, 24'h000060};
      vt[10] = '{OP_SHR,  24'h800000, 24'h000017, 8'h00, 24'h000001};
      vt[11] = '{OP_SHR,  24'hFFFFFF, 24'h00001F, 8'h00, 24'h000000};
      vt[12] = '{OP_ROT3, 24'hE00001, 24'h000000, 8'h00, 24'h00000F};
      vt[13] = '{OP_ROT3, 24'h123456, 24'h000000, 8'h00, 24'h91A2B0};
      vt[14] = '{OP_MOVA, 24'h123456, 24'h000777, 8'h00, 24'h123456};
      vt[15] = '{OP_LDI,  24'h111111, 24'h222222, 8'hA5, 24'h0000A5};
      vt[16] = '{OP_NOP,  24'h111111, 24'h222222, 8'h00, 24'h5A5A5A};
      vt[17] = '{OP_MUL,  24'h000003, 24'h000003, 8'h00, 24'h000009};
      vt[18] = '{OP_MUL,  24'h001000, 24'h001000, 8'h00, 24'h000000};
      vt[19] = '{OP_MUL,  24'hFFFFFF, 24'hFFFFFF, 8'h00, 24'h000001};
      vt[20] = '{4'hF,    24'h000001, 24'h000002, 8'h00, 24'h5A5A5A};
      vt[21] = '{4'hC,    24'h000001, 24'h000002, 8'h00, 24'h5A5A5A};

      // Reset, with an LDI offered on the same edges: reset must win.
      rst = 1'b1;
      issue_valid = 1'b1;
      issue_op = OP_LDI;
      issue_dst = 4'd9;
      issue_srca = '0;
      issue_srcb = '0;
      issue_imm = 8'h77;
      pl_en = 1'b0;
      pl_addr = '0;
      pl_val = '0;
      for (int i = 0; i < 16; i++) arch[i] = '0;
      repeat (3) @(negedge clk);
      check("rst_issue_ready", issue_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_we", we, 1'b0);
      check("rst_dst", dst, 32'd0);
      check("rst_data", data, 32'd0);
      check("rst_err", err, 1'b0);
      issue_valid = 1'b0;
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_priority_r9", rf[9], 32'd0);

      for (int i = 0; i < 22; i++) begin
         preload(12, vt[i].a);
         preload(11, vt[i].b);
         preload(4, 24'h5A5A5A);
         issue(vt[i].op, 4, 12, 11, vt[i].imm);
         drain();
         check($sformatf("vec%0d_r4", i), rf[4], vt[i].exp);
      end

      // Dependent ADD back-to-back (E forward), then with a NOP gap (W forward).
      preload(12, 24'h000001);
      preload(4, 24'h0);
      preload(5, 24'h0);
      issue(OP_ADD, 4, 12, 12, 8'h0);
      issue(OP_ADD, 5, 4, 4, 8'h0);
      drain();
      check("fwd_e_r5", rf[5], 24'h000004);
      preload(4, 24'h0);
      preload(5, 24'h0);
      issue(OP_ADD, 4, 12, 12, 8'h0);
      issue(OP_NOP, 0, 0, 0, 8'h0);
      issue(OP_ADD, 5, 4, 4, 8'h0);
      drain();
      check("fwd_w_r5", rf[5], 24'h000004);

      // MUL with a dependent ADD held on the issue port for the whole MUL.
      preload(11, 24'h000003);
      preload(5, 24'h0);
      preload(6, 24'h0);
      issue(OP_MUL, 5, 11, 11, 8'h0);
      t0 = cyc;
      issue(OP_ADD, 6, 5, 5, 8'h0);
      check("mul_next_accept_cyc", cyc, t0 + 25);
      drain();
      check("mul_r5", rf[5], 24'h000009);
      check("mul_dep_r6", rf[6], 24'h000012);

      // Reset in MUL cycle 10: result discarded, ready the next cycle.
      preload(11, 24'h000003);
      preload(5, 24'h5A5A5A);
      issue(OP_MUL, 5, 11, 11, 8'h0);
      repeat (9) @(negedge clk);
      mul_hi = cyc;
      exp_q.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mul_ready", issue_ready, 1'b1);
      check("rst_mul_busy", busy, 1'b0);
      check("rst_mul_we", we, 1'b0);
      repeat (30) @(negedge clk);
      check("rst_mul_no_write", rf[5], 24'h5A5A5A);
      for (int i = 0; i < 16; i++) arch[i] = rf[i];

      // Random program, hazard-dense register choice half of the time.
      for (int i = 0; i < 16; i++) preload(i, 24'($urandom));
      for (int k = 0; k < 300; k++) begin
         rop = 4'($urandom_range(0, 15));
         if (rop == 4'd11 && $urandom_range(0, 3) != 0) rop = 4'd0;
         if ($urandom_range(0, 1) == 1) begin
            rd  = int'($urandom_range(0, 3));
            rsa = int'($urandom_range(0, 3));
            rsb = int'($urandom_range(0, 3));
         end else begin
            rd  = int'($urandom_range(0, 15));
            rsa = int'($urandom_range(0, 15));
            rsb = int'($urandom_range(0, 15));
         end
         issue(rop, rd, rsa, rsb, 8'($urandom));
         if ($urandom_range(0, 4) == 0) @(negedge clk);
      end
      drain();
      for (int i = 0; i < 16; i++) check($sformatf("final_r%0d", i), rf[i], arch[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
